// File: rtl/rotary_encode_if.sv
`default_nettype none
// ============================================================================
// Module   : rotary_encode_if
// Brief    : Command handshake and quadrature output bundle for rotary_encode.
// Revision : 1.0
// ============================================================================
interface rotary_encode_if #(
    parameter int CNT_W = 8
);
    logic             step_valid;
    logic             step_ready;
    logic             step_left;
    logic [CNT_W-1:0] step_count;
    logic             rotary_a;
    logic             rotary_b;
    logic             busy;
    logic             step_done;

    modport master (
        output step_valid, step_left, step_count,
        input  step_ready, rotary_a, rotary_b, busy, step_done
    );

    modport slave (
        input  step_valid, step_left, step_count,
        output step_ready, rotary_a, rotary_b, busy, step_done
    );
endinterface
`default_nettype wire

// File: rtl/rotary_encode.sv
`default_nettype none
// ============================================================================
// Module   : rotary_encode
// Brief    : Turns step commands (count + direction) into an A/B quadrature pair.
// Revision : 1.0
// ============================================================================
module rotary_encode #(
    parameter int PHASE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int CNT_W        = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    rotary_encode_if.slave bus
);
    localparam int C_TMAX = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
    localparam int C_TW   = (C_TMAX > 1) ? $clog2(C_TMAX) : 1;
    localparam logic [C_TW-1:0] C_PH_LAST  = C_TW'(PHASE_CYCLES - 1);
    localparam logic [C_TW-1:0] C_GAP_LAST = C_TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit              C_HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_PH2  = 3'd2,
        ST_PH3  = 3'd3,
        ST_PH4  = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [C_TW-1:0]  r_timer,  w_timer_nxt;
    logic [CNT_W-1:0] r_remain, w_remain_nxt;
    logic             r_left,   w_left_nxt;
    logic             r_a, r_b, r_ready, r_done;
    logic             w_done_nxt;
    logic [1:0]       w_ba_nxt;
    logic             w_ph_end;
    logic             w_gap_end;
    logic             w_more;

    // {b,a} for each state; the two directions walk the Gray cycle in opposite order
    function automatic logic [1:0] phase_ba(input state_t st, input logic left);
        case (st)
            ST_PH1:  phase_ba = left ? 2'b10 : 2'b01;
            ST_PH2:  phase_ba = 2'b11;
            ST_PH3:  phase_ba = left ? 2'b01 : 2'b10;
            default: phase_ba = 2'b00;
        endcase
    endfunction

    assign w_ph_end  = (r_timer == C_PH_LAST);
    assign w_gap_end = (r_timer == C_GAP_LAST);
    assign w_more    = (r_remain != '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_remain_nxt = r_remain;
        w_left_nxt   = r_left;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A zero-length command completes the handshake without leaving IDLE
                if (bus.step_valid && (bus.step_count != '0)) begin
                    w_state_nxt  = ST_PH1;
                    w_timer_nxt  = '0;
                    w_remain_nxt = bus.step_count;
                    w_left_nxt   = bus.step_left;
                end
            end
            ST_PH1, ST_PH2: begin
                if (w_ph_end) begin
                    w_state_nxt = (r_state == ST_PH1) ? ST_PH2 : ST_PH3;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + C_TW'(1);
                end
            end
            ST_PH3: begin
                if (w_ph_end) begin
                    w_state_nxt  = ST_PH4;
                    w_timer_nxt  = '0;
                    w_done_nxt   = 1'b1;
                    w_remain_nxt = r_remain - CNT_W'(1);
                end else begin
                    w_timer_nxt = r_timer + C_TW'(1);
                end
            end
            ST_PH4: begin
                if (w_ph_end) begin
                    w_timer_nxt = '0;
                    if (C_HAS_GAP) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = w_more ? ST_PH1 : ST_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer + C_TW'(1);
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    w_timer_nxt = '0;
                    w_state_nxt = w_more ? ST_PH1 : ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + C_TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
        w_ba_nxt = phase_ba(w_state_nxt, w_left_nxt);
    end

    // Outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_remain <= '0;
            r_left   <= 1'b0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_remain <= w_remain_nxt;
            r_left   <= w_left_nxt;
            r_a      <= w_ba_nxt[0];
            r_b      <= w_ba_nxt[1];
            r_ready  <= (w_state_nxt == ST_IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign bus.step_ready = r_ready;
    assign bus.busy       = ~r_ready;
    assign bus.rotary_a   = r_a;
    assign bus.rotary_b   = r_b;
    assign bus.step_done  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_rotary_encode.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotary_encode
// Brief    : Scoreboard bench for rotary_encode (default timing and PHASE=1/GAP=0).
// Revision : 1.0
// ============================================================================
module tb_rotary_encode;
    localparam int CNT_W = 8;

    typedef struct {
        int         cyc;
        logic [3:0] v;     // {ready, done, b, a}
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    logic rst_seen = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t       eq[2][$];
    logic       dq[2][$];
    logic [1:0] prev_ba[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_seen <= !rst_n;

    rotary_encode_if #(.CNT_W(CNT_W)) bus0 ();
    rotary_encode_if #(.CNT_W(CNT_W)) bus1 ();

    rotary_encode #(.PHASE_CYCLES(4), .GAP_CYCLES(4), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    rotary_encode #(.PHASE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    function automatic logic [1:0] ref_ba(input logic left, input int p);
        logic [1:0] r_tab[4];
        logic [1:0] l_tab[4];
        r_tab = '{2'b01, 2'b11, 2'b10, 2'b00};
        l_tab = '{2'b10, 2'b11, 2'b01, 2'b00};
        return left ? l_tab[p] : r_tab[p];
    endfunction

    task automatic push(input int id, input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        eq[id].push_back(e);
    endtask

    // Expected trace of one command whose valid cycle is 'base'
    task automatic push_cmd(input int id, input int base, input logic left, input int count);
        int ph  = (id == 0) ? 4 : 1;
        int gap = (id == 0) ? 4 : 0;
        int per = 4 * ph + gap;
        for (int s = 0; s < count; s++) begin
            for (int p = 0; p < 4; p++)
                for (int t = 0; t < ph; t++)
                    push(id, base + 1 + s * per + p * ph + t,
                         {1'b0, (p == 3 && t == 0), ref_ba(left, p)});
            for (int g = 0; g < gap; g++)
                push(id, base + 1 + s * per + 4 * ph + g, 4'b0000);
            dq[id].push_back(left);
        end
        push(id, base + 1 + count * per, 4'b1000);
    endtask

    task automatic drive(input int id, input logic v, input logic left, input int count);
        if (id == 0) begin
            bus0.step_valid = v;
            bus0.step_left  = left;
            bus0.step_count = CNT_W'(count);
        end else begin
            bus1.step_valid = v;
            bus1.step_left  = left;
            bus1.step_count = CNT_W'(count);
        end
    endtask

    task automatic issue(input int id, input logic left, input int count, output int base);
        @(negedge clk);
        base = cyc;
        drive(id, 1'b1, left, count);
        push_cmd(id, base, left, count);
        @(negedge clk);
        drive(id, 1'b0, ~left, 8'hA5);
    endtask

    task automatic wait_idle(input int id, input int budget);
        int n = 0;
        while (eq[id].size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (eq[id].size() != 0) begin
            n_bad++;
            $display("FAIL timeout_dut%0d: %0d expectations left, required 0", id, eq[id].size());
            eq[id].delete();
        end
        n_cmp++;
        if (dq[id].size() != 0) begin
            n_bad++;
            $display("FAIL decoder_events_dut%0d: %0d events missing, required 0", id, dq[id].size());
            dq[id].delete();
        end
    endtask

    task automatic mon(input int id, input logic [3:0] act, input logic bsy);
        exp_t       e;
        logic       matched = 1'b0;
        logic [1:0] d;
        logic       ev_left;
        n_cmp++;
        if (bsy !== ~act[3]) begin
            n_bad++;
            $display("FAIL busy_dut%0d cyc %0d: busy=%b, required %b", id, cyc, bsy, ~act[3]);
        end
        while (eq[id].size() > 0 && eq[id][0].cyc <= cyc) begin
            e = eq[id].pop_front();
            matched = 1'b1;
            n_cmp++;
            if (act !== e.v || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL trace_dut%0d cyc %0d: {ready,done,b,a}=%b, required %b at cyc %0d",
                         id, cyc, act, e.v, e.cyc);
            end
        end
        if (!matched) begin
            n_cmp++;
            if (act[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL stray_done_dut%0d cyc %0d: step_done=%b, required 0", id, cyc, act[2]);
            end
        end
        d = act[1:0] ^ prev_ba[id];
        if (d != 2'b00) begin
            n_cmp++;
            if (d == 2'b11 && !rst_seen) begin
                n_bad++;
                $display("FAIL gray_dut%0d cyc %0d: {b,a} %b -> %b, required one-line change",
                         id, cyc, prev_ba[id], act[1:0]);
            end
        end
        // Loop-back decoder: a detent completes when the lines return to 00
        if (act[1:0] == 2'b00 && !rst_seen && (prev_ba[id] == 2'b10 || prev_ba[id] == 2'b01)) begin
            ev_left = (prev_ba[id] == 2'b01);
            n_cmp++;
            if (dq[id].size() == 0) begin
                n_bad++;
                $display("FAIL decoder_dut%0d cyc %0d: event left=%b, required no event", id, cyc, ev_left);
            end else if (dq[id].pop_front() !== ev_left) begin
                n_bad++;
                $display("FAIL decoder_dut%0d cyc %0d: event left=%b, required %b", id, cyc, ev_left, ~ev_left);
            end
        end
        prev_ba[id] = act[1:0];
    endtask

    initial begin
        prev_ba[0] = 2'b00;
        prev_ba[1] = 2'b00;
    end

    always @(negedge clk) begin
        mon(0, {bus0.step_ready, bus0.step_done, bus0.rotary_b, bus0.rotary_a}, bus0.busy);
        mon(1, {bus1.step_ready, bus1.step_done, bus1.rotary_b, bus1.rotary_a}, bus1.busy);
    end

    initial begin
        int b;
        drive(0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            push(0, cyc + i, 4'b1000);
            push(1, cyc + i, 4'b1000);
        end
        rst_n = 1'b1;
        wait_idle(0, 10);
        wait_idle(1, 10);

        // Single right step: 01/11/10 over 1-12, done at 13, ready at 21
        issue(0, 1'b0, 1, b);
        wait_idle(0, 100);

        // Three left steps: done at 13, 33, 53; ready at 61
        issue(0, 1'b1, 3, b);
        wait_idle(0, 200);

        // Zero-length command is a no-op
        issue(0, 1'b0, 0, b);
        for (int i = 2; i <= 6; i++) push(0, b + i, 4'b1000);
        wait_idle(0, 50);

        // Commands while busy: a pulse is ignored, a held valid is taken when ready returns
        issue(0, 1'b0, 2, b);
        while (cyc < b + 6) @(negedge clk);
        drive(0, 1'b1, 1'b1, 5);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0);
        while (cyc < b + 30) @(negedge clk);
        drive(0, 1'b1, 1'b1, 1);
        while (cyc < b + 41) @(negedge clk);
        push_cmd(0, b + 41, 1'b1, 1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0);
        wait_idle(0, 200);

        // Reset during {b,a}=11 of step 2 of 5
        issue(0, 1'b0, 5, b);
        while (cyc < b + 25) @(negedge clk);
        while (eq[0].size() > 0 && eq[0][eq[0].size()-1].cyc > b + 25)
            eq[0].delete(eq[0].size() - 1);
        dq[0].delete();
        for (int i = 26; i <= 30; i++) push(0, b + i, 4'b1000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(0, 50);
        issue(0, 1'b1, 1, b);
        wait_idle(0, 100);

        // PHASE=1, GAP=0, maximum count: 4-cycle period, ready at 1021
        issue(1, 1'b0, 255, b);
        wait_idle(1, 1100);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
